// File: rtl/instruction_fetch_controller.sv
// -----------------------------------------------------------------------------
// instruction_fetch_controller
//
// Purpose:
//   Sequences instruction fetch for a simple in-order core. It asks instruction
//   memory for the word at the current program counter, hands that word to
//   decode, and then writes the next program counter value. That value is
//   either pc + PC_INCREMENT or a branch/jump target supplied by execute.
//   Each instruction passes through three states:
//     FETCH   - imem_req high until imem_ack
//     DELIVER - inst_valid high until decode accepts or a redirect drops it
//     UPDATE  - one-cycle pc_enable pulse that writes next_pc
//   A redirect that arrives while a memory access is outstanding is held in
//   target_reg. The access is allowed to complete, its data is discarded, and
//   the stored target is written to the PC.
//
// Optional feature (macro FETCH_MISALIGN_TRAP_EN):
//   When defined, a FETCH with pc[1:0] != 0 issues no memory request. A NOP
//   is presented to decode instead, with fetch_misaligned=1. When undefined,
//   pc[1:0] is ignored and fetch_misaligned is constant 0.
//
// Ports:
//   clock            in   system clock
//   reset            in   asynchronous, active-high reset
//   pc[31:0]         in   current program counter register value
//   pc_enable        out  program counter write enable
//   next_pc[31:0]    out  value written into the PC when pc_enable=1
//   imem_req         out  instruction memory request
//   imem_addr[31:0]  out  word-aligned fetch address
//   imem_ack         in   single-cycle memory response strobe
//   imem_rdata[31:0] in   instruction word, valid with imem_ack
//   inst_valid       out  instruction available to decode
//   inst_ready       in   decode accepts the instruction
//   inst[31:0]       out  fetched instruction
//   inst_pc[31:0]    out  address of inst
//   redirect_valid   in   single-cycle control-flow change request
//   redirect_target  in   new PC for a redirect
//   fetch_misaligned out  misaligned-fetch flag, qualified by inst_valid
// -----------------------------------------------------------------------------
module instruction_fetch_controller #(
    parameter logic [31:0] PC_INCREMENT = 32'd4,
    parameter logic [31:0] NOP_INSTR    = 32'h00000013
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] pc,
    output logic        pc_enable,
    output logic [31:0] next_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        fetch_misaligned
);

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        DELIVER = 2'd1,
        UPDATE  = 2'd2
    } state_t;

    state_t      state_reg;
    // Low for the first cycle after reset and for a completed access. This
    // keeps imem_req low during and immediately after reset. It also ensures
    // that only acks answering a live request are honoured.
    logic        req_armed_reg;
    logic        pc_enable_reg;
    logic        inst_valid_reg;
    logic        redirect_pending_reg;
    logic [31:0] inst_reg;
    logic [31:0] inst_pc_reg;
    logic [31:0] npc_reg;
    logic [31:0] target_reg;

    logic        misaligned_pc;
    logic        fetch_done;
    logic        redirect_hit;
    logic        deliver_exit;
    logic [31:0] redirect_sel;

    // A fetch completes on a live ack. With the trap enabled, it also completes
    // on a misaligned PC, for which no request is ever raised.
    assign fetch_done   = (state_reg == FETCH) && req_armed_reg && (imem_ack || misaligned_pc);
    assign redirect_hit = redirect_valid || redirect_pending_reg;
    // A redirect arriving in the completion cycle is newer than the stored one.
    assign redirect_sel = redirect_valid ? redirect_target : target_reg;
    assign deliver_exit = (state_reg == DELIVER) && (redirect_valid || inst_ready);

    assign imem_req   = (state_reg == FETCH) && req_armed_reg && !misaligned_pc;
    assign imem_addr  = {pc[31:2], 2'b00};
    assign pc_enable  = pc_enable_reg;
    // A redirect during the write cycle overrides the sequential value.
    assign next_pc    = ((state_reg == UPDATE) && redirect_valid) ? redirect_target : npc_reg;
    assign inst_valid = inst_valid_reg;
    assign inst       = inst_reg;
    assign inst_pc    = inst_pc_reg;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misaligned_reg;

    assign misaligned_pc    = (pc[1:0] != 2'b00);
    assign fetch_misaligned = misaligned_reg;

    // Set when a misaligned fetch enters DELIVER; cleared when DELIVER is left.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            misaligned_reg <= 1'b0;
        end else if (fetch_done && !redirect_hit) begin
            misaligned_reg <= misaligned_pc;
        end else if (deliver_exit) begin
            misaligned_reg <= 1'b0;
        end
    end
`else
    assign misaligned_pc    = 1'b0;
    assign fetch_misaligned = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg            <= FETCH;
            req_armed_reg        <= 1'b0;
            pc_enable_reg        <= 1'b0;
            inst_valid_reg       <= 1'b0;
            redirect_pending_reg <= 1'b0;
            inst_reg             <= NOP_INSTR;
            inst_pc_reg          <= 32'd0;
            npc_reg              <= 32'd0;
            target_reg           <= 32'd0;
        end else begin
            case (state_reg)
                FETCH: begin
                    req_armed_reg <= 1'b1;
                    if (fetch_done) begin
                        req_armed_reg <= 1'b0;
                        if (redirect_hit) begin
                            // The access completed, but the stream is stale.
                            // Drop the data and write the target.
                            npc_reg       <= redirect_sel;
                            pc_enable_reg <= 1'b1;
                            state_reg     <= UPDATE;
                        end else begin
                            inst_reg       <= misaligned_pc ? NOP_INSTR : imem_rdata;
                            inst_pc_reg    <= pc;
                            inst_valid_reg <= 1'b1;
                            state_reg      <= DELIVER;
                        end
                    end else if (redirect_valid) begin
                        // The outstanding access is never cancelled. Remember
                        // the latest target until the access completes.
                        target_reg           <= redirect_target;
                        redirect_pending_reg <= 1'b1;
                    end
                end

                DELIVER: begin
                    if (redirect_valid) begin
                        npc_reg <= redirect_target;
                    end else if (inst_ready) begin
                        npc_reg <= pc + PC_INCREMENT;
                    end
                    if (deliver_exit) begin
                        inst_valid_reg <= 1'b0;
                        pc_enable_reg  <= 1'b1;
                        state_reg      <= UPDATE;
                    end
                end

                UPDATE: begin
                    pc_enable_reg        <= 1'b0;
                    redirect_pending_reg <= 1'b0;
                    req_armed_reg        <= 1'b1;
                    state_reg            <= FETCH;
                    // Keep npc_reg equal to what the PC actually received.
                    if (redirect_valid) begin
                        npc_reg <= redirect_target;
                    end
                end

                default: begin
                    state_reg <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: doc/instruction_fetch_controller.md
Name: instruction_fetch_controller

Overview:
- Drives the write side of the program counter register: produces next_pc and pc_enable, and reads back the registered pc.
- Fetches the instruction at pc from instruction memory over a req/ack handshake.
- Presents the fetched word to decode over a valid/ready handshake.
- Applies branch/jump redirects from execute, including redirects that arrive while a memory access is outstanding.

Parameters:
PC_INCREMENT, 4, sequential PC step in bytes
NOP_INSTR, 32'h00000013, word presented on inst when a fetch is suppressed (addi x0,x0,0)

Ports:
clock  in  1  system clock
reset  in  1  reset, asynchronous, active-high
pc  in  32  current value of the program counter register
pc_enable  out  1  write enable to the program counter register
next_pc  out  32  value written into the program counter register when pc_enable=1
imem_req  out  1  instruction memory request
imem_addr  out  32  fetch address, equal to {pc[31:2],2'b00}
imem_ack  in  1  instruction memory response valid (single cycle)
imem_rdata  in  32  instruction word, valid when imem_ack=1
inst_valid  out  1  fetched instruction available to decode
inst_ready  in  1  decode accepts instruction
inst  out  32  fetched instruction
inst_pc  out  32  address of inst (equals pc while inst_valid=1)
redirect_valid  in  1  execute requests a control-flow change (single cycle)
redirect_target  in  32  new PC for a redirect
fetch_misaligned  out  1  instruction-address-misaligned flag, qualified by inst_valid

Behaviour:
- State machine with three states:
  - FETCH: imem_req=1.
  - DELIVER: inst_valid=1.
  - UPDATE: pc_enable=1.
- Reset: state=FETCH, inst register=NOP_INSTR, npc_q=0, redirect_pending=0, target_q=0.
  - Registered outputs during reset: pc_enable=0, inst_valid=0, fetch_misaligned=0, inst=NOP_INSTR.
  - imem_req=1 from the first clock after reset is released.
- FETCH:
  - imem_req stays high until imem_ack. Memory latency is unbounded, 0 wait cycles minimum (ack is sampled no earlier than the cycle after req rises).
  - On imem_ack with no pending redirect and redirect_valid=0: capture imem_rdata into inst, go to DELIVER.
  - On imem_ack with redirect_pending=1 or redirect_valid=1: discard rdata, npc_q<=target (redirect_valid=1 takes precedence over the stored target), go to UPDATE.
  - redirect_valid without ack: target_q<=redirect_target, redirect_pending<=1, stay in FETCH. An outstanding access is never cancelled.
- DELIVER:
  - inst, inst_pc and inst_valid are held stable until the state is left.
  - redirect_valid=1 (has priority over inst_ready in the same cycle): instruction dropped, npc_q<=redirect_target, go to UPDATE.
  - inst_ready=1: npc_q<=pc+PC_INCREMENT, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000), go to UPDATE.
  - Otherwise stay in DELIVER.
- UPDATE: lasts exactly one cycle.
  - pc_enable=1.
  - next_pc = redirect_valid ? redirect_target : npc_q. A late redirect overrides the sequential value.
  - redirect_pending cleared; go to FETCH.
- next_pc equals npc_q whenever pc_enable=0.
- Throughput: one instruction per 3 cycles with zero-wait memory and an always-ready decode.
  - Cycle 1, FETCH: req high, ack returned.
  - Cycle 2, DELIVER: accepted.
  - Cycle 3, UPDATE.
- A redirect is never lost.
  - Consecutive redirects while pending: the latest target wins.
  - Every redirect causes exactly one PC write to its target before the next fetch.
- Reset asserted mid-operation: return to FETCH immediately; drop any captured instruction and pending redirect.
  - A memory ack arriving during reset is ignored.
  - After reset, the first fetch uses whatever pc holds.

Optional Feature:
- Macro FETCH_MISALIGN_TRAP_EN, defined: in FETCH with pc[1:0]!=0, no request is issued (imem_req=0).
  - Next cycle: enter DELIVER with inst=NOP_INSTR and fetch_misaligned=1.
  - Exit from DELIVER follows the normal rules.
  - A pending redirect takes priority: go directly to UPDATE with the target.
- Macro undefined: pc[1:0] is ignored, imem_addr always word-aligned, fetch_misaligned tied to 0.

Test Plan:
- Reset release with pc=0x00400000, ack after 2 cycles with rdata=0x00500093, inst_ready=1 → inst_valid with inst=0x00500093, inst_pc=0x00400000; then pc_enable pulse with next_pc=0x00400004.
- Sequential stream of 4 fetches, zero-wait memory, ready always 1 → pc_enable once every 3 cycles; next_pc steps 0x00400004/08/0C/10.
- DELIVER with inst_ready=0 for 5 cycles → inst and inst_pc stable, pc_enable=0; then redirect_valid with target 0x00400100 together with inst_ready=1 → instruction dropped; next_pc=0x00400100.
- redirect to 0x00401000 while in FETCH with ack delayed 4 cycles → rdata discarded, inst_valid never asserts, single pc_enable with next_pc=0x00401000.
- pc=0xFFFFFFFC accepted → next_pc=0x00000000. Reset pulse while in DELIVER → inst_valid=0 and pc_enable=0 asynchronously; imem_req=1 after release.
- With FETCH_MISALIGN_TRAP_EN, pc=0x00400002 → imem_req stays 0; inst_valid with inst=0x00000013 and fetch_misaligned=1.
